// File: rtl/xosera_bus_host_if.sv
// Request/response and Xosera byte-bus signals of xosera_bus_host, bundled for the host and its environment.
// The master modport is the host's view; slave is the view of whatever drives requests and models the responder.
interface xosera_bus_host_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_rd_nwr_i;
   logic [3:0]  req_reg_num_i;
   logic [15:0] req_data_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        bus_cs_n_o;
   logic        bus_rd_nwr_o;
   logic [3:0]  bus_reg_num_o;
   logic        bus_bytesel_o;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe_o;
   logic [7:0]  bus_data_i;
   logic        bus_intr_i;
   logic        intr_clear_i;
   logic        intr_pending_o;

   modport master (
      input  req_valid_i, req_rd_nwr_i, req_reg_num_i, req_data_i,
      input  bus_data_i, bus_intr_i, intr_clear_i,
      output req_ready_o, rsp_valid_o, rsp_data_o,
      output bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o,
      output bus_data_o, bus_data_oe_o, intr_pending_o
   );

   modport slave (
      output req_valid_i, req_rd_nwr_i, req_reg_num_i, req_data_i,
      output bus_data_i, bus_intr_i, intr_clear_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o,
      input  bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o,
      input  bus_data_o, bus_data_oe_o, intr_pending_o
   );
endinterface

// File: rtl/xosera_bus_host.sv
// Splits 16-bit register reads/writes into two timed byte strobes on the Xosera 8-bit bus.
// Optional interrupt latch enabled by defining XOSERA_BUS_HOST_INTR_EN.
module xosera_bus_host #(
   parameter int CS_CYCLES      = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input logic               clk,
   input logic               reset_i,
   xosera_bus_host_if.master hif
);

   if (CS_CYCLES < 1 || CS_CYCLES > 15) begin : g_bad_cs_cycles
      $error("xosera_bus_host: CS_CYCLES must be in 1..15");
   end
   if (RECOVER_CYCLES < 0 || RECOVER_CYCLES > 15) begin : g_bad_recover_cycles
      $error("xosera_bus_host: RECOVER_CYCLES must be in 0..15");
   end

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

   state_t      state_q, state_d;
   logic        byte_q, byte_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        accept, sample, byte_done;
   logic        rd_nwr_q;
   logic [3:0]  reg_num_q;
   logic [15:0] data_q;
   logic [15:0] rsp_data_q;
   logic        drive_oe;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         byte_q      <= 1'b0;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rd_nwr_q    <= 1'b0;
         reg_num_q   <= 4'd0;
         data_q      <= 16'd0;
         rsp_data_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         byte_q      <= byte_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         if (accept) begin
            rd_nwr_q  <= hif.req_rd_nwr_i;
            reg_num_q <= hif.req_reg_num_i;
            data_q    <= hif.req_data_i;
         end
         if (sample) begin
            if (byte_q) rsp_data_q[7:0]  <= hif.bus_data_i;
            else        rsp_data_q[15:8] <= hif.bus_data_i;
         end
      end
   end

   // cnt_q counts down the remaining cycles of STROBE and RECOVER; byte_done closes out one byte.
   always_comb begin
      state_d     = state_q;
      byte_d      = byte_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      accept      = 1'b0;
      sample      = 1'b0;
      byte_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (hif.req_valid_i) begin
               accept  = 1'b1;
               state_d = SETUP;
               byte_d  = 1'b0;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = 4'(CS_CYCLES - 1);
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
               sample  = rd_nwr_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (RECOVER_CYCLES == 0) begin
               byte_done = 1'b1;
            end else begin
               state_d = RECOVER;
               cnt_d   = 4'(RECOVER_CYCLES - 1);
            end
         end
         RECOVER: begin
            if (cnt_q == 4'd0) byte_done = 1'b1;
            else               cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      if (byte_done) begin
         if (byte_q) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
         end else begin
            state_d = SETUP;
            byte_d  = 1'b1;
         end
      end
   end

   assign drive_oe = !rd_nwr_q && (state_q == SETUP || state_q == STROBE || state_q == HOLD);

   assign hif.req_ready_o   = (state_q == IDLE);
   assign hif.rsp_valid_o   = rsp_valid_q;
   assign hif.rsp_data_o    = rsp_data_q;
   assign hif.bus_cs_n_o    = (state_q != STROBE);
   assign hif.bus_rd_nwr_o  = rd_nwr_q;
   assign hif.bus_reg_num_o = reg_num_q;
   assign hif.bus_bytesel_o = byte_q;
   assign hif.bus_data_oe_o = drive_oe;
   assign hif.bus_data_o    = drive_oe ? (byte_q ? data_q[7:0] : data_q[15:8]) : 8'h00;

`ifdef XOSERA_BUS_HOST_INTR_EN
   // Two synchronizer stages plus one history stage for edge detection; a new edge beats a clear.
   logic [2:0] intr_sync_q;
   logic       intr_pending_q;
   logic       intr_rise;

   assign intr_rise = intr_sync_q[1] && !intr_sync_q[2];

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         intr_sync_q    <= 3'b000;
         intr_pending_q <= 1'b0;
      end else begin
         intr_sync_q <= {intr_sync_q[1:0], hif.bus_intr_i};
         if (intr_rise)             intr_pending_q <= 1'b1;
         else if (hif.intr_clear_i) intr_pending_q <= 1'b0;
      end
   end

   assign hif.intr_pending_o = intr_pending_q;
`else
   logic intr_unused;
   assign intr_unused        = hif.bus_intr_i | hif.intr_clear_i;
   assign hif.intr_pending_o = 1'b0;
`endif

endmodule

// File: tb/tb_xosera_bus_host.sv
// Self-checking bench for xosera_bus_host: default timing (dut0) and minimal timing (dut1).
// Expected bus activity is derived from each transaction's position within its byte windows.
module tb_xosera_bus_host;
   logic clk = 1'b0;
   logic reset_i;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   xosera_bus_host_if hif0 ();
   xosera_bus_host_if hif1 ();

   xosera_bus_host #(.CS_CYCLES(4), .RECOVER_CYCLES(2)) dut0 (
      .clk(clk), .reset_i(reset_i), .hif(hif0.master));
   xosera_bus_host #(.CS_CYCLES(1), .RECOVER_CYCLES(0)) dut1 (
      .clk(clk), .reset_i(reset_i), .hif(hif1.master));

   logic        req_valid [2];
   logic        req_rd    [2];
   logic [3:0]  req_reg   [2];
   logic [15:0] req_data  [2];
   logic [7:0]  bus_din   [2];
   logic        intr_in   [2];
   logic        intr_clr  [2];
   logic [15:0] obs_bus   [2];
   logic [17:0] obs_rsp   [2];
   logic        obs_pend  [2];
   logic [15:0] model_rsp [2];

   assign hif0.req_valid_i   = req_valid[0];
   assign hif0.req_rd_nwr_i  = req_rd[0];
   assign hif0.req_reg_num_i = req_reg[0];
   assign hif0.req_data_i    = req_data[0];
   assign hif0.bus_data_i    = bus_din[0];
   assign hif0.bus_intr_i    = intr_in[0];
   assign hif0.intr_clear_i  = intr_clr[0];
   assign hif1.req_valid_i   = req_valid[1];
   assign hif1.req_rd_nwr_i  = req_rd[1];
   assign hif1.req_reg_num_i = req_reg[1];
   assign hif1.req_data_i    = req_data[1];
   assign hif1.bus_data_i    = bus_din[1];
   assign hif1.bus_intr_i    = intr_in[1];
   assign hif1.intr_clear_i  = intr_clr[1];

   // Bus view packed as {cs_n, oe, data[7:0], bytesel, reg_num[3:0], rd_nwr}; response as {ready, valid, data}.
   assign obs_bus[0]  = {hif0.bus_cs_n_o, hif0.bus_data_oe_o, hif0.bus_data_o,
                         hif0.bus_bytesel_o, hif0.bus_reg_num_o, hif0.bus_rd_nwr_o};
   assign obs_bus[1]  = {hif1.bus_cs_n_o, hif1.bus_data_oe_o, hif1.bus_data_o,
                         hif1.bus_bytesel_o, hif1.bus_reg_num_o, hif1.bus_rd_nwr_o};
   assign obs_rsp[0]  = {hif0.req_ready_o, hif0.rsp_valid_o, hif0.rsp_data_o};
   assign obs_rsp[1]  = {hif1.req_ready_o, hif1.rsp_valid_o, hif1.rsp_data_o};
   assign obs_pend[0] = hif0.intr_pending_o;
   assign obs_pend[1] = hif1.intr_pending_o;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Cycle k (1-based) after the accept cycle falls in byte (k-1)/P at offset (k-1)%P,
   // where offset 0 is setup, 1..CS strobe, CS+1 hold and the rest recovery.
   function automatic logic [15:0] expected_bus(input int cs, input int rc, input int k,
                                                input logic rd, input logic [3:0] rn, input logic [15:0] wd);
      int         p, b, off;
      logic       active, csn, oe;
      logic [7:0] d;
      p      = 2 + cs + rc;
      b      = (k - 1) / p;
      off    = (k - 1) % p;
      active = (off <= cs + 1);
      csn    = !(off >= 1 && off <= cs);
      oe     = active && !rd;
      d      = oe ? ((b == 0) ? wd[15:8] : wd[7:0]) : 8'h00;
      if (active) return {csn, oe, d, 1'(b), rn, rd};
      return {csn, oe, d, 6'b000000};
   endfunction

   task automatic apply_stimulus(input int sel, input logic rd, input logic [3:0] rn, input logic [15:0] wd,
                                 input logic [7:0] rb0, input logic [7:0] rb1,
                                 input bit keep_valid, input bit expect_now);
      int          cs, rc, p, waits, off, b;
      logic [15:0] mask;
      cs    = (sel == 1) ? 1 : 4;
      rc    = (sel == 1) ? 0 : 2;
      p     = 2 + cs + rc;
      waits = 0;
      req_rd[sel]    = rd;
      req_reg[sel]   = rn;
      req_data[sel]  = wd;
      req_valid[sel] = 1'b1;
      while (!obs_rsp[sel][17] && waits < 40) begin
         @(posedge clk); #1;
         waits++;
      end
      check_output("accept_within_budget", (waits < 40) ? 1 : 0, 1);
      if (waits >= 40) begin
         req_valid[sel] = 1'b0;
         return;
      end
      if (expect_now) check_output("back_to_back_accept", waits, 0);
      @(posedge clk); #1;
      if (!keep_valid) req_valid[sel] = 1'b0;
      req_rd[sel]   = 1'($urandom);
      req_reg[sel]  = 4'($urandom);
      req_data[sel] = 16'($urandom);
      for (int k = 1; k <= 2 * p; k++) begin
         off  = (k - 1) % p;
         b    = (k - 1) / p;
         mask = (off <= cs + 1) ? 16'hFFFF : 16'hFFC0;
         bus_din[sel] = (off == cs) ? ((b == 0) ? rb0 : rb1) : 8'($urandom);
         check_output($sformatf("bus_dut%0d_k%0d", sel, k), obs_bus[sel] & mask,
                      expected_bus(cs, rc, k, rd, rn, wd));
         check_output($sformatf("busy_dut%0d_k%0d", sel, k), 32'(obs_rsp[sel][17:16]), 0);
         @(posedge clk); #1;
      end
      bus_din[sel] = 8'h00;
      if (rd) model_rsp[sel] = {rb0, rb1};
      check_output($sformatf("rsp_dut%0d", sel), 32'(obs_rsp[sel]), {14'd0, 2'b11, model_rsp[sel]});
      check_output($sformatf("bus_idle_dut%0d", sel), 32'(obs_bus[sel] & 16'hFFC0), 32'h8000);
   endtask

   initial begin
      reset_i = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0; req_rd[s] = 1'b0; req_reg[s] = 4'd0; req_data[s] = 16'd0;
         bus_din[s] = 8'd0; intr_in[s] = 1'b0; intr_clr[s] = 1'b0; model_rsp[s] = 16'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_output($sformatf("reset_bus_dut%0d", s), 32'(obs_bus[s]), 32'h8000);
         check_output($sformatf("reset_rsp_dut%0d", s), 32'(obs_rsp[s]), 32'h20000);
         check_output($sformatf("reset_pend_dut%0d", s), 32'(obs_pend[s]), 0);
      end
      reset_i = 1'b0;
      @(posedge clk); #1;
      check_output("ready_after_reset", 32'(obs_rsp[0][17]), 1);

      $display("[TB] directed write/read on default timing");
      apply_stimulus(0, 1'b0, 4'd3, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0);
      apply_stimulus(0, 1'b1, 4'd9, 16'h0000, 8'hAB, 8'hCD, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 4'd5, 16'h5A5A, 8'h00, 8'h00, 1'b1, 1'b0);
      apply_stimulus(0, 1'b0, 4'd6, 16'hC3E1, 8'h00, 8'h00, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_output("rsp_single_pulse", 32'(obs_rsp[0][17:16]), 32'h2);

      $display("[TB] randomized transactions");
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(0, 1'($urandom), 4'($urandom), 16'($urandom),
                        8'($urandom), 8'($urandom), 1'b0, 1'b0);
      end

      $display("[TB] reset during second strobe cycle of byte 0");
      req_rd[0] = 1'b0; req_reg[0] = 4'd7; req_data[0] = 16'hF00D; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_output("cs_low_before_reset", 32'(obs_bus[0][15]), 0);
      #2 reset_i = 1'b1;
      #1;
      check_output("async_reset_bus", 32'(obs_bus[0]), 32'h8000);
      check_output("async_reset_rsp", 32'(obs_rsp[0]), 32'h20000);
      model_rsp[0] = 16'd0;
      model_rsp[1] = 16'd0;
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_output($sformatf("no_rsp_after_reset_%0d", i), 32'(obs_rsp[0][17:16]), 32'h2);
      end
      apply_stimulus(0, 1'b1, 4'd2, 16'h0000, 8'h5C, 8'h3A, 1'b0, 1'b0);

      $display("[TB] minimal timing instance");
      apply_stimulus(1, 1'b0, 4'd5, 16'hBEEF, 8'h00, 8'h00, 1'b0, 1'b0);
      apply_stimulus(1, 1'b1, 4'd1, 16'h0000, 8'h96, 8'h69, 1'b0, 1'b1);

      $display("[TB] interrupt latch");
`ifdef XOSERA_BUS_HOST_INTR_EN
      begin
         int lat;
         lat = 0;
         intr_in[0] = 1'b1;
         while (!obs_pend[0] && lat < 3) begin
            @(posedge clk); #1;
            lat++;
         end
         check_output("intr_set_within_3", 32'(obs_pend[0]), 1);
         intr_in[0] = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check_output("intr_sticky", 32'(obs_pend[0]), 1);
         intr_in[0] = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         intr_clr[0] = 1'b1;
         @(posedge clk); #1;
         intr_clr[0] = 1'b0;
         check_output("intr_set_beats_clear", 32'(obs_pend[0]), 1);
         intr_in[0] = 1'b0;
         repeat (3) @(posedge clk);
         #1 intr_clr[0] = 1'b1;
         @(posedge clk); #1;
         intr_clr[0] = 1'b0;
         check_output("intr_cleared", 32'(obs_pend[0]), 0);
      end
`else
      intr_in[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_output("intr_disabled_high", 32'(obs_pend[0]), 0);
      intr_in[0] = 1'b0;
      intr_clr[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      intr_clr[0] = 1'b0;
      check_output("intr_disabled_low", 32'(obs_pend[0]), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
